sample_unpacker: RTL and testbench

//  Receive-side inverse of the sample packer feeding packet_streamer: consumes the 16-bit

---
 rtl/sample_unpacker.sv | 184 ++++++++++++++++++
 tb/tb_sample_unpacker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_unpacker.sv
// sample_unpacker
//   Rebuilds per-instant samples from the packed 16-bit word stream produced by
//   the sample packer. Mode 0 carries 3-channel 2-bit I/Q (3 words = 4 samples),
//   modes 1/2 carry 8-bit samples (2 per word), other modes are discarded.
// Ports
//   clk_adc, clk_adc_reset_n : clock, asynchronous active-low reset
//   mode                     : packing mode, latched on the first word of a packet
//   in_data/in_en/in_packet_end : word stream (no backpressure)
//   clear                    : sync pulse clearing overflow/frame_error/pkt_count
//   out_sample/out_valid/out_ready/out_last : sample stream with handshake
//   overflow, frame_error    : sticky status flags
//   pkt_count                : packets ended without error (wraps)
module sample_unpacker #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned PKT_CNT_W  = 16
) (
  input  logic                 clk_adc,
  input  logic                 clk_adc_reset_n,
  input  logic [7:0]           mode,
  input  logic [15:0]          in_data,
  input  logic                 in_en,
  input  logic                 in_packet_end,
  input  logic                 clear,
  output logic [11:0]          out_sample,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 overflow,
  output logic                 frame_error,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {W0 = 2'd0, W1 = 2'd1, W2 = 2'd2} widx_e;

  // Input capture stage: the word is registered first and assembled one cycle
  // later, giving the completing-word -> out_valid latency of two edges.
  logic                 in_v_q, in_end_q;
  logic [15:0]          in_data_q;
  logic [7:0]           in_mode_q;

  logic                 first_q, first_d;
  logic [7:0]           pmode_q, pmode_d;
  widx_e                widx_q, widx_d;
  logic [15:0]          asm0_q, asm0_d, asm1_q, asm1_d;

  logic [47:0]          mem_data_q [FIFO_DEPTH];
  logic                 mem_m0_q   [FIFO_DEPTH];
  logic                 mem_last_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [1:0]           sidx_q, sidx_d;

  logic                 overflow_q, overflow_d;
  logic                 frame_error_q, frame_error_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;

  logic [7:0]           cur_mode;
  logic                 is_m0, is_m8, complete, push_ok, fire, pop;
  logic [47:0]          push_data, head_data;
  logic                 head_m0;
  logic [1:0]           last_idx;
  logic [11:0]          sel_sample;

  always_comb begin
    cur_mode      = first_q ? in_mode_q : pmode_q;
    is_m0         = (cur_mode == 8'd0);
    is_m8         = (cur_mode == 8'd1) || (cur_mode == 8'd2);
    complete      = in_v_q && (is_m0 ? (widx_q == W2) : is_m8);
    push_data     = is_m0 ? {asm0_q, asm1_q, in_data_q} : {32'd0, in_data_q};

    head_data     = mem_data_q[rd_ptr_q];
    head_m0       = mem_m0_q[rd_ptr_q];
    last_idx      = head_m0 ? 2'd3 : 2'd1;
    out_valid     = (cnt_q != '0);
    fire          = out_valid && out_ready;
    pop           = fire && (sidx_q == last_idx);
    // A full FIFO still accepts a group when its head leaves this same cycle.
    push_ok       = complete && ((cnt_q != DEPTH_C) || pop);

    sel_sample    = '0;
    if (head_m0) begin
      case (sidx_q)
        2'd0:    sel_sample = head_data[47:36];
        2'd1:    sel_sample = head_data[35:24];
        2'd2:    sel_sample = head_data[23:12];
        default: sel_sample = head_data[11:0];
      endcase
    end else begin
      sel_sample = (sidx_q == 2'd0) ? {4'd0, head_data[15:8]} : {4'd0, head_data[7:0]};
    end
    out_sample    = out_valid ? sel_sample : '0;
    out_last      = out_valid && mem_last_q[rd_ptr_q] && (sidx_q == last_idx);

    first_d       = in_v_q ? in_end_q : first_q;
    pmode_d       = (in_v_q && first_q) ? in_mode_q : pmode_q;
    asm0_d        = asm0_q;
    asm1_d        = asm1_q;
    widx_d        = widx_q;
    if (in_v_q) begin
      if (is_m0 && (widx_q == W0)) asm0_d = in_data_q;
      if (is_m0 && (widx_q == W1)) asm1_d = in_data_q;
      if (in_end_q) begin
        widx_d = W0;
      end else if (is_m0) begin
        case (widx_q)
          W0:      widx_d = W1;
          W1:      widx_d = W2;
          default: widx_d = W0;
        endcase
      end
    end

    wr_ptr_d      = wr_ptr_q + AW'(push_ok);
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    cnt_d         = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    sidx_d        = sidx_q;
    if (fire) sidx_d = pop ? 2'd0 : sidx_q + 2'd1;

    // Flag set wins over a coincident clear; count clear wins over increment.
    overflow_d    = overflow_q;
    if (clear) overflow_d = 1'b0;
    if (complete && !push_ok) overflow_d = 1'b1;
    frame_error_d = frame_error_q;
    if (clear) frame_error_d = 1'b0;
    if (in_v_q && in_end_q && is_m0 && (widx_q != W2)) frame_error_d = 1'b1;
    pkt_count_d   = pkt_count_q;
    if (in_v_q && in_end_q && push_ok) pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
    if (clear) pkt_count_d = '0;
  end

  always_ff @(posedge clk_adc or negedge clk_adc_reset_n) begin
    if (!clk_adc_reset_n) begin
      in_v_q        <= 1'b0;
      in_end_q      <= 1'b0;
      in_data_q     <= '0;
      in_mode_q     <= '0;
      first_q       <= 1'b1;
      pmode_q       <= '0;
      widx_q        <= W0;
      asm0_q        <= '0;
      asm1_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      sidx_q        <= '0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
      pkt_count_q   <= '0;
    end else begin
      in_v_q        <= in_en;
      in_end_q      <= in_en && in_packet_end;
      in_data_q     <= in_data;
      in_mode_q     <= mode;
      first_q       <= first_d;
      pmode_q       <= pmode_d;
      widx_q        <= widx_d;
      asm0_q        <= asm0_d;
      asm1_q        <= asm1_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      sidx_q        <= sidx_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
      pkt_count_q   <= pkt_count_d;
    end
  end

  always_ff @(posedge clk_adc) begin
    if (push_ok) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_m0_q[wr_ptr_q]   <= is_m0;
      mem_last_q[wr_ptr_q] <= in_end_q;
    end
  end

  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_sample_unpacker.sv
module tb_sample_unpacker;

  logic        clk_adc = 1'b0;
  logic        clk_adc_reset_n = 1'b0;
  logic [7:0]  mode = 8'd0;
  logic [15:0] in_data = '0;
  logic        in_en = 1'b0;
  logic        in_packet_end = 1'b0;
  logic        clear = 1'b0;
  logic [11:0] out_sample;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        overflow;
  logic        frame_error;
  logic [15:0] pkt_count;

  int ncomp = 0;
  int nfail = 0;
  logic rdy_rand = 1'b0;
  logic [12:0] sb[$];  // {sample, last}

  sample_unpacker #(.FIFO_DEPTH(2), .PKT_CNT_W(16)) dut (
    .clk_adc(clk_adc), .clk_adc_reset_n(clk_adc_reset_n), .mode(mode),
    .in_data(in_data), .in_en(in_en), .in_packet_end(in_packet_end), .clear(clear),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow), .frame_error(frame_error),
    .pkt_count(pkt_count)
  );

  always #5 clk_adc = ~clk_adc;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every accepted sample is compared to the oldest expectation.
  always @(negedge clk_adc) begin
    if (clk_adc_reset_n && out_valid && out_ready) begin
      ncomp++;
      assert (sb.size() != 0) else begin
        nfail++;
        $error("FAIL out_unexpected: observed %0h expected no sample", {out_sample, out_last});
      end
      if (sb.size() != 0) begin
        logic [12:0] e;
        e = sb.pop_front();
        assert ({out_sample, out_last} === e) else begin
          nfail++;
          $error("FAIL out_sample: observed %0h/%0b expected %0h/%0b",
                 out_sample, out_last, e[12:1], e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_adc);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic word(input logic [15:0] d, input logic e);
    in_en = 1'b1; in_data = d; in_packet_end = e;
    tick();
    in_en = 1'b0; in_packet_end = 1'b0;
  endtask

  task automatic exp_m0(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                        input logic last);
    logic [47:0] g;
    g = {w0, w1, w2};
    for (int i = 0; i < 4; i++) sb.push_back({g[47-12*i -: 12], last && (i == 3)});
  endtask

  task automatic exp_m8(input logic [15:0] w, input logic last);
    sb.push_back({4'h0, w[15:8], 1'b0});
    sb.push_back({4'h0, w[7:0], last});
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
    tick();
    check(tag, 48'(sb.size()), 48'd0);
  endtask

  initial begin
    logic [15:0] a, b, c;

    // Reset state
    #12;
    check("rst_valid", 48'(out_valid), 48'd0);
    check("rst_sample", 48'(out_sample), 48'd0);
    check("rst_flags", 48'({overflow, frame_error, out_last}), 48'd0);
    check("rst_pkt", 48'(pkt_count), 48'd0);
    tick();
    clk_adc_reset_n = 1'b1;
    tick();

    // 1: mode 0 basic group, latency and back-to-back samples
    mode = 8'd0;
    exp_m0(16'h1B6C, 16'h5A0F, 16'hE4D2, 1'b1);
    word(16'h1B6C, 1'b0);
    word(16'h5A0F, 1'b0);
    word(16'hE4D2, 1'b1);
    check("t1_lat_early", 48'(out_valid), 48'd0);
    tick();
    check("t1_lat_valid", 48'(out_valid), 48'd1);
    check("t1_first", 48'(out_sample), 48'h1B6);
    for (int i = 0; i < 4; i++) tick();
    check("t1_consecutive", 48'(sb.size()), 48'd0);
    check("t1_idle", 48'(out_valid), 48'd0);
    check("t1_pkt", 48'(pkt_count), 48'd1);

    // 2: 8-bit mode, mid-packet mode change ignored
    mode = 8'd1;
    exp_m8(16'h1234, 1'b0);
    word(16'h1234, 1'b0);
    mode = 8'd3;
    exp_m8(16'hA53C, 1'b1);
    word(16'hA53C, 1'b1);
    word(16'hFFFF, 1'b1);  // discard mode packet
    mode = 8'd2;
    exp_m8(16'h77C1, 1'b1);
    word(16'h77C1, 1'b1);
    wait_drain("t2_drain");
    check("t2_pkt", 48'(pkt_count), 48'd3);
    check("t2_flags", 48'({overflow, frame_error}), 48'd0);

    // 3: overflow with consumer stalled
    mode = 8'd0;
    out_ready = 1'b0;
    exp_m0(16'h0123, 16'h4567, 16'h89AB, 1'b0);
    exp_m0(16'hCDEF, 16'hFEDC, 16'hBA98, 1'b0);
    word(16'h0123, 1'b0); word(16'h4567, 1'b0); word(16'h89AB, 1'b0);
    word(16'hCDEF, 1'b0); word(16'hFEDC, 1'b0); word(16'hBA98, 1'b0);
    word(16'h5555, 1'b0); word(16'hAAAA, 1'b0); word(16'h3C3C, 1'b1);
    tick();
    check("t3_overflow", 48'(overflow), 48'd1);
    check("t3_held", 48'(out_sample), 48'h012);
    check("t3_pkt", 48'(pkt_count), 48'd3);
    out_ready = 1'b1;
    wait_drain("t3_drain");
    check("t3_empty", 48'(out_valid), 48'd0);

    // 4: frame error, recovery, clear
    word(16'hDEAD, 1'b0);
    word(16'hBEEF, 1'b1);
    tick();
    check("t4_frame_err", 48'(frame_error), 48'd1);
    check("t4_no_out", 48'(out_valid), 48'd0);
    check("t4_pkt", 48'(pkt_count), 48'd3);
    exp_m0(16'h2468, 16'hACE0, 16'h1357, 1'b1);
    word(16'h2468, 1'b0); word(16'hACE0, 1'b0); word(16'h1357, 1'b1);
    wait_drain("t4_drain");
    check("t4_pkt_after", 48'(pkt_count), 48'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_clear", 48'({overflow, frame_error, pkt_count}), 48'd0);

    // 5: sustained packer rate, ready held high
    for (int g = 0; g < 240; g++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
      exp_m0(a, b, c, g == 239);
      word(a, 1'b0); word(b, 1'b0); word(c, g == 239);
      tick();
    end
    wait_drain("t5_drain");
    check("t5_no_overflow", 48'(overflow), 48'd0);
    check("t5_pkt", 48'(pkt_count), 48'd1);

    // 5b: random out_ready (75%), source paced so the FIFO never overruns
    rdy_rand = 1'b1;
    for (int g = 0; g < 30; g++) begin
      for (int i = 0; i < 200 && sb.size() > 4; i++) tick();
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
      exp_m0(a, b, c, (g % 10) == 9);
      word(a, 1'b0); word(b, 1'b0); word(c, (g % 10) == 9);
      tick();
    end
    wait_drain("t5b_drain");
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t5b_no_overflow", 48'(overflow), 48'd0);
    check("t5b_pkt", 48'(pkt_count), 48'd4);

    // 6: asynchronous reset mid-packet with a pending group
    out_ready = 1'b0;
    word(16'h1111, 1'b0); word(16'h2222, 1'b0); word(16'h3333, 1'b0);
    word(16'h4444, 1'b0);
    tick();
    check("t6_pending", 48'(out_valid), 48'd1);
    clk_adc_reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 48'(out_valid), 48'd0);
    check("t6_rst_outs", 48'({out_sample, out_last, overflow, frame_error}), 48'd0);
    check("t6_rst_pkt", 48'(pkt_count), 48'd0);
    sb.delete();
    tick(); tick();
    clk_adc_reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    exp_m0(16'h9876, 16'h5432, 16'h10FE, 1'b1);
    word(16'h9876, 1'b0); word(16'h5432, 1'b0); word(16'h10FE, 1'b1);
    wait_drain("t6_drain");
    check("t6_pkt", 48'(pkt_count), 48'd1);
    check("t6_flags", 48'({overflow, frame_error}), 48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
